bcd_dd_seq: RTL

- Sequential binary-to-BCD converter using the double-dabble (shift and add-3) algorithm.
- Applies the per-digit add-3 correction cell to each BCD digit, one bit per clock, under a small FSM.
- Lets a single narrow correction datapath serve any input width.
- Sits between binary counters/ALU results and the BCD display/output logic.

---
 rtl/bcd_dd_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bcd_dd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
// A single add-3 correction layer serves any input width; the result is held until the next done.
module bcd_dd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   work_q, work_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [BcdW-1:0]   work_corr;
  logic [BcdW-1:0]   work_shift;
  logic              last_bit;

  // Codes 10-15 cannot arise from a legal sequence; clamp them to zero.
  function automatic logic [3:0] add3(input logic [3:0] d);
    if (d >= 4'd10) begin
      return 4'd0;
    end else if (d >= 4'd5) begin
      return d + 4'd3;
    end else begin
      return d;
    end
  endfunction

  always_comb begin
    work_corr = '0;
    for (int i = 0; i < DIGITS; i++) begin
      work_corr[4*i +: 4] = add3(work_q[4*i +: 4]);
    end
  end

  assign work_shift = {work_corr[BcdW-2:0], bin_q[WIDTH-1]};
  assign last_bit   = (cnt_q == CntW'(1));

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bin_d   = bin_in;
          work_d  = '0;
          acc_d   = 1'b0;
          cnt_d   = CntW'(WIDTH);
          state_d = StConv;
        end
      end
      StConv: begin
        bin_d  = bin_q << 1;
        work_d = work_shift;
        acc_d  = acc_q | work_corr[BcdW-1];
        cnt_d  = cnt_q - CntW'(1);
        if (last_bit) begin
          // Publish on the edge entering DONE so outputs never show partial results.
          bcd_d   = work_shift;
          ovf_d   = acc_q | work_corr[BcdW-1];
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bin_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule
